// File: rtl/mini_cpu_issue_ctrl.sv
// Issue/writeback controller for a small ALU datapath: accepts 16-bit instructions,
// keeps a 4-entry register file, sequences ALU ops through their latency and retires results.
module mini_cpu_issue_ctrl #(
    parameter int DATA_W      = 8,
    parameter int ALU_LATENCY = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              instr_valid_i,
    output logic              instr_ready_o,
    input  logic [15:0]       instr_i,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    output logic [1:0]        alu_sel_o,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              alu_zero_i,
    input  logic              alu_carry_i,
    output logic              wb_done_o,
    output logic              flag_zero_o,
    output logic              flag_carry_o,
    output logic              halted_o,
    input  logic [1:0]        dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_WB   = 2'b10
    } state_e;

    localparam logic [2:0] OP_LOADI = 3'b100;
    localparam logic [2:0] OP_HALT  = 3'b111;

    state_e            state_q;
    logic [2:0]        cnt_q;
    logic [2:0]        cnt_d;
    logic [DATA_W-1:0] regs_q [4];
    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic [1:0]        alu_sel_q;
    logic [1:0]        rd_q;
    logic              wb_done_q;
    logic              flag_zero_q;
    logic              flag_carry_q;
    logic              halted_q;

    logic              accept_s;
    logic [2:0]        op_s;
    logic [1:0]        rd_s;
    logic [1:0]        rs1_s;
    logic [1:0]        rs2_s;
    logic [7:0]        imm_s;

    assign op_s  = instr_i[15:13];
    assign rd_s  = instr_i[12:11];
    assign rs1_s = instr_i[10:9];
    assign rs2_s = instr_i[8:7];
    assign imm_s = instr_i[7:0];

    // Ready is decoded from state only so it never depends on instr_valid_i.
    assign instr_ready_o = (state_q == ST_IDLE) && !halted_q;
    assign accept_s      = instr_valid_i && instr_ready_o;
    assign cnt_d         = cnt_q - 3'd1;

    assign alu_a_o      = alu_a_q;
    assign alu_b_o      = alu_b_q;
    assign alu_sel_o    = alu_sel_q;
    assign wb_done_o    = wb_done_q;
    assign flag_zero_o  = flag_zero_q;
    assign flag_carry_o = flag_carry_q;
    assign halted_o     = halted_q;
    assign dbg_data_o   = regs_q[dbg_addr_i];

    // Issue/execute/writeback sequencer; reset discards any in-flight ALU op.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= 2'b00;
            rd_q         <= 2'b00;
            wb_done_q    <= 1'b0;
            flag_zero_q  <= 1'b0;
            flag_carry_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            wb_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        case (op_s)
                            3'b000, 3'b001, 3'b010, 3'b011: begin
                                alu_a_q   <= regs_q[rs1_s];
                                alu_b_q   <= regs_q[rs2_s];
                                alu_sel_q <= op_s[1:0];
                                rd_q      <= rd_s;
                                cnt_q     <= 3'(ALU_LATENCY);
                                state_q   <= ST_EXEC;
                            end
                            OP_LOADI: begin
                                regs_q[rd_s] <= DATA_W'(imm_s);
                                wb_done_q    <= 1'b1;
                            end
                            OP_HALT: begin
                                halted_q <= 1'b1;
                            end
                            default: begin
                                state_q <= ST_IDLE;
                            end
                        endcase
                    end
                end
                ST_EXEC: begin
                    // The last decrement lands on the edge ALU_LATENCY after accept.
                    cnt_q <= cnt_d;
                    if (cnt_q == 3'd1) begin
                        state_q <= ST_WB;
                    end
                end
                ST_WB: begin
                    regs_q[rd_q] <= alu_result_i;
                    flag_zero_q  <= alu_zero_i;
                    flag_carry_q <= alu_carry_i;
                    wb_done_q    <= 1'b1;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mini_cpu_issue_ctrl.sv
// Randomised scoreboard bench for mini_cpu_issue_ctrl with a latency-aware ALU stub
// that presents garbage until the operands have been stable for ALU_LATENCY cycles.
module tb_mini_cpu_issue_ctrl;

    localparam int DW  = 8;
    localparam int LAT = 3;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          instr_valid_i;
    logic          instr_ready_o;
    logic [15:0]   instr_i;
    logic [DW-1:0] alu_a_o;
    logic [DW-1:0] alu_b_o;
    logic [1:0]    alu_sel_o;
    logic [DW-1:0] alu_result_i;
    logic          alu_zero_i;
    logic          alu_carry_i;
    logic          wb_done_o;
    logic          flag_zero_o;
    logic          flag_carry_o;
    logic          halted_o;
    logic [1:0]    dbg_addr_i;
    logic [DW-1:0] dbg_data_o;

    always #5 clk_i = ~clk_i;

    mini_cpu_issue_ctrl #(.DATA_W(DW), .ALU_LATENCY(LAT)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o), .instr_i(instr_i),
        .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_sel_o(alu_sel_o),
        .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i), .alu_carry_i(alu_carry_i),
        .wb_done_o(wb_done_o), .flag_zero_o(flag_zero_o), .flag_carry_o(flag_carry_o),
        .halted_o(halted_o), .dbg_addr_i(dbg_addr_i), .dbg_data_o(dbg_data_o)
    );

    // ALU arithmetic: returns {carry/borrow, result}
    function automatic logic [DW:0] alu_f(input logic [1:0] sel, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
        case (sel)
            2'b00:   return {1'b0, a} + {1'b0, b};
            2'b01:   return {1'b0, a} - {1'b0, b};
            2'b10:   return {1'b0, a & b};
            default: return {1'b0, a | b};
        endcase
    endfunction

    // ALU stub: output valid only once operands have been stable LAT cycles
    int            age = 100;
    logic [DW-1:0] last_a = '0;
    logic [DW-1:0] last_b = '0;
    logic [1:0]    last_sel = 2'b00;
    logic [DW-1:0] junk = 8'h5A;
    logic [DW:0]   alu_r;

    always @(posedge clk_i) begin
        if ({alu_a_o, alu_b_o, alu_sel_o} != {last_a, last_b, last_sel}) age <= 1;
        else if (age < 100) age <= age + 1;
        last_a   <= alu_a_o;
        last_b   <= alu_b_o;
        last_sel <= alu_sel_o;
        junk     <= DW'($urandom);
    end

    assign alu_r = alu_f(alu_sel_o, alu_a_o, alu_b_o);

    always_comb begin
        alu_result_i = junk;
        alu_zero_i   = junk[0];
        alu_carry_i  = junk[1];
        if (age >= LAT) begin
            alu_result_i = alu_r[DW-1:0];
            alu_zero_i   = (alu_r[DW-1:0] == '0);
            alu_carry_i  = alu_r[DW];
        end
    end

    // Behavioural reference model
    typedef struct {
        int            due;
        int            acc;
        bit            is_alu;
        logic [1:0]    rd;
        logic [DW-1:0] val;
        logic          fz;
        logic          fc;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [1:0]    sel;
    } exp_t;

    exp_t          q[$];
    exp_t          mon_e;
    logic [DW-1:0] m_regs [4];
    logic          m_fz = 1'b0;
    logic          m_fc = 1'b0;
    bit            m_halt = 1'b0;
    int            halt_edge = 0;
    int            busy_until = 0;
    int            cyc = 0;
    int            errors = 0;
    int            checks = 0;
    bit            started = 1'b0;
    bit            tb_done = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic bit exp_halted();
        return m_halt && (cyc >= halt_edge);
    endfunction

    function automatic bit exp_ready();
        return !exp_halted() && (cyc >= busy_until);
    endfunction

    task automatic model_accept(input logic [15:0] ins);
        exp_t       e;
        logic [2:0] op;
        logic [DW:0] r;
        op       = ins[15:13];
        e.acc    = cyc + 1;
        e.rd     = ins[12:11];
        e.is_alu = 1'b0;
        e.a      = '0;
        e.b      = '0;
        e.sel    = 2'b00;
        if (op < 3'd4) begin
            e.is_alu = 1'b1;
            e.a      = m_regs[ins[10:9]];
            e.b      = m_regs[ins[8:7]];
            e.sel    = op[1:0];
            r        = alu_f(e.sel, e.a, e.b);
            m_regs[e.rd] = r[DW-1:0];
            m_fz     = (r[DW-1:0] == '0);
            m_fc     = r[DW];
            e.due    = e.acc + LAT + 1;
            busy_until = e.due;
            e.val    = r[DW-1:0];
            e.fz     = m_fz;
            e.fc     = m_fc;
            q.push_back(e);
        end else if (op == 3'd4) begin
            m_regs[e.rd] = DW'(ins[7:0]);
            e.val    = DW'(ins[7:0]);
            e.due    = e.acc;
            e.fz     = m_fz;
            e.fc     = m_fc;
            q.push_back(e);
        end else if (op == 3'd7) begin
            m_halt    = 1'b1;
            halt_edge = e.acc;
        end
    endtask

    task automatic issue(input logic [15:0] ins);
        int waited;
        waited        = 0;
        instr_i       = ins;
        instr_valid_i = 1'b1;
        while (1) begin
            chk("instr_ready", instr_ready_o, exp_ready());
            chk("halted", halted_o, exp_halted());
            if (instr_ready_o) begin
                model_accept(ins);
                @(negedge clk_i);
                break;
            end
            if (waited >= (m_halt ? 4 : 40)) begin
                if (!m_halt) fail_now("accept_timeout");
                instr_valid_i = 1'b0;
                break;
            end
            waited++;
            @(negedge clk_i);
        end
    endtask

    task automatic idle(input int n);
        instr_valid_i = 1'b0;
        instr_i       = 16'($urandom);
        repeat (n) begin
            chk("instr_ready", instr_ready_o, exp_ready());
            chk("halted", halted_o, exp_halted());
            @(negedge clk_i);
        end
    endtask

    task automatic do_reset();
        reset_i       = 1'b0;
        instr_valid_i = 1'b0;
        q.delete();
        for (int i = 0; i < 4; i++) m_regs[i] = '0;
        m_fz = 1'b0; m_fc = 1'b0; m_halt = 1'b0;
        halt_edge = 0; busy_until = 0;
        @(negedge clk_i);
        reset_i = 1'b1;
        chk("rst_alu_a", alu_a_o, 32'd0);
        chk("rst_alu_b", alu_b_o, 32'd0);
        chk("rst_alu_sel", alu_sel_o, 32'd0);
        chk("rst_flag_zero", flag_zero_o, 32'd0);
        chk("rst_flag_carry", flag_carry_o, 32'd0);
        chk("rst_wb_done", wb_done_o, 32'd0);
    endtask

    function automatic logic [15:0] mk(input logic [2:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs1, input logic [1:0] rs2);
        return {op, rd, rs1, rs2, 7'd0};
    endfunction

    function automatic logic [15:0] ldi(input logic [1:0] rd, input logic [7:0] imm);
        return {3'b100, rd, 3'b000, imm};
    endfunction

    // Monitor: retires scoreboard entries on wb_done and sweeps the register file when quiet
    initial begin
        int sweep;
        sweep      = 0;
        dbg_addr_i = 2'd0;
        wait (started);
        forever begin
            @(negedge clk_i);
            #1;
            if (tb_done) break;
            if (reset_i) begin
                if (wb_done_o) begin
                    if (q.size() == 0) begin
                        fail_now("spurious_wb_done");
                    end else begin
                        mon_e = q.pop_front();
                        chk("wb_cycle", cyc, mon_e.due);
                        dbg_addr_i = mon_e.rd;
                        #1;
                        chk("wb_data", dbg_data_o, mon_e.val);
                        chk("flag_zero", flag_zero_o, mon_e.fz);
                        chk("flag_carry", flag_carry_o, mon_e.fc);
                    end
                end else if (q.size() > 0 && q[0].due <= cyc) begin
                    fail_now("missing_wb_done");
                    void'(q.pop_front());
                end
                if (q.size() > 0 && q[0].is_alu && q[0].acc == cyc) begin
                    chk("alu_a", alu_a_o, q[0].a);
                    chk("alu_b", alu_b_o, q[0].b);
                    chk("alu_sel", alu_sel_o, q[0].sel);
                end
                if (q.size() == 0) begin
                    dbg_addr_i = 2'(sweep);
                    #1;
                    chk("reg_sweep", dbg_data_o, m_regs[sweep]);
                    sweep = (sweep + 1) % 4;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ins;
        for (int i = 0; i < 4; i++) m_regs[i] = '0;
        reset_i       = 1'b0;
        instr_valid_i = 1'b0;
        instr_i       = 16'd0;
        repeat (3) @(negedge clk_i);
        reset_i = 1'b1;
        chk("init_alu_a", alu_a_o, 32'd0);
        chk("init_alu_b", alu_b_o, 32'd0);
        chk("init_alu_sel", alu_sel_o, 32'd0);
        chk("init_wb_done", wb_done_o, 32'd0);
        chk("init_flags", {flag_zero_o, flag_carry_o}, 32'd0);
        started = 1'b1;

        // Directed sequences: add, sub-to-zero, and, add with carry, held valid across busy
        issue(ldi(2'd0, 8'd10));
        issue(ldi(2'd1, 8'd5));
        issue(mk(3'b000, 2'd2, 2'd0, 2'd1));
        idle(2);
        issue(ldi(2'd3, 8'd5));
        issue(mk(3'b001, 2'd2, 2'd3, 2'd1));
        issue(mk(3'b010, 2'd2, 2'd0, 2'd1));
        issue(ldi(2'd0, 8'd200));
        issue(ldi(2'd1, 8'd100));
        issue(mk(3'b000, 2'd2, 2'd0, 2'd1));
        issue(ldi(2'd3, 8'd7));
        issue(mk(3'b001, 2'd1, 2'd1, 2'd1));
        issue(mk(3'b101, 2'd0, 2'd0, 2'd0));
        issue(mk(3'b110, 2'd1, 2'd2, 2'd3));
        idle(3);

        // Random traffic, HALT excluded
        repeat (300) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            ins        = 16'($urandom);
            ins[15:13] = 3'($urandom_range(0, 6));
            issue(ins);
        end
        idle(LAT + 3);

        // Reset while an ALU op is in flight: nothing retires
        issue(ldi(2'd0, 8'd3));
        issue(mk(3'b000, 2'd2, 2'd0, 2'd0));
        do_reset();
        idle(LAT + 4);

        // HALT blocks further accepts until reset
        issue(ldi(2'd1, 8'd9));
        issue(mk(3'b111, 2'd0, 2'd0, 2'd0));
        issue(ldi(2'd1, 8'd3));
        idle(6);
        do_reset();
        idle(3);
        issue(ldi(2'd3, 8'd42));
        idle(4);

        tb_done = 1'b1;
        repeat (2) @(negedge clk_i);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
